// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
//
// I2C target with a 4 x 8-bit register file. Decodes START/STOP, matches a
// 7-bit address, accepts a pointer byte followed by data writes, and returns
// register contents on reads. The pointer auto-increments (wrapping 3 -> 0)
// after every written byte and after every read byte the controller ACKs.
//
// Ports
//   clk        in   system clock, at least 10x the SCL frequency
//   rst_n      in   synchronous active-low reset
//   scl_in     in   raw SCL pin (asynchronous)
//   sda_in     in   raw SDA pin (asynchronous)
//   sda_oe     out  1 = pull SDA low, 0 = release (open drain)
//   regs_out   out  {reg3, reg2, reg1, reg0}
//   wr_strobe  out  one-cycle pulse when a register is written
//   wr_index   out  index of the written register, valid with wr_strobe
//   busy       out  addressed transaction active (address ACK .. STOP/START/NACK)
//   dbg_state  out  current FSM state encoding
//
// Handshake: there is no valid/ready pair on this block; wr_strobe is a
// single-cycle qualifier for wr_index and the matching byte in regs_out.
// ---------------------------------------------------------------------------
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [31:0] regs_out,
    output logic        wr_strobe,
    output logic [1:0]  wr_index,
    output logic        busy,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
    } state_t;

    // Synchronizers plus history flop; idle bus level is 1.
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    // Registered bus events.
    logic scl_rise_d, scl_fall_d, start_d, stop_d;
    logic scl_rise_q, scl_fall_q, start_q, stop_q;

    state_t          state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic [1:0]      ptr_q;
    logic [3:0][7:0] regs_q;
    logic            rw_q;
    logic            rd_load_q;
    logic            sda_oe_q;
    logic            busy_q;
    logic            wr_strobe_q;
    logic [1:0]      wr_index_q;
    logic [7:0]      rx_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_h_q <= 1'b1;
            sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_h_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_in; scl_s2_q <= scl_s1_q; scl_h_q <= scl_s2_q;
            sda_s1_q <= sda_in; sda_s2_q <= sda_s1_q; sda_h_q <= sda_s2_q;
        end
    end

    assign scl_rise_d = scl_s2_q & ~scl_h_q;
    assign scl_fall_d = ~scl_s2_q & scl_h_q;
    assign start_d    = scl_s2_q & scl_h_q & ~sda_s2_q & sda_h_q;
    assign stop_d     = scl_s2_q & scl_h_q & sda_s2_q & ~sda_h_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    // sda_h_q holds the SDA level that was current when scl_rise_q was set,
    // so it is the bit sampled on that SCL rise.
    assign rx_byte = {shift_q[6:0], sda_h_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 2'd0;
            regs_q      <= '0;
            rw_q        <= 1'b0;
            rd_load_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= 2'd0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_q) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= 3'd0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else if (stop_q) begin
                state_q  <= S_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (scl_rise_q) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;  // wraps to 0 after bit 8
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == S_ADDR) begin
                                    if (rx_byte[7:1] == TARGET_ADDR) begin
                                        rw_q    <= rx_byte[0];
                                        state_q <= S_ADDR_ACK;
                                    end else begin
                                        state_q <= S_WAIT;
                                    end
                                end else if (state_q == S_PTR) begin
                                    ptr_q   <= rx_byte[1:0];
                                    state_q <= S_PTR_ACK;
                                end else begin
                                    regs_q[ptr_q] <= rx_byte;
                                    wr_strobe_q   <= 1'b1;
                                    wr_index_q    <= ptr_q;
                                    ptr_q         <= ptr_q + 2'd1;
                                    state_q       <= S_WDATA_ACK;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        // First fall (after bit 8) starts the ACK; second fall
                        // (after the 9th clock) ends it.
                        if (scl_fall_q) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                                if (state_q == S_ADDR_ACK) busy_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                if (state_q == S_ADDR_ACK && rw_q) begin
                                    state_q   <= S_RDATA;
                                    shift_q   <= regs_q[ptr_q];
                                    sda_oe_q  <= ~regs_q[ptr_q][7];
                                    rd_load_q <= 1'b0;
                                end else if (state_q == S_ADDR_ACK) begin
                                    state_q <= S_PTR;
                                end else begin
                                    state_q <= S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_fall_q) begin
                            if (rd_load_q) begin
                                shift_q   <= regs_q[ptr_q];
                                sda_oe_q  <= ~regs_q[ptr_q][7];
                                bit_cnt_q <= 3'd0;
                                rd_load_q <= 1'b0;
                            end else if (bit_cnt_q == 3'd7) begin
                                sda_oe_q <= 1'b0;  // release for controller ACK/NACK
                                state_q  <= S_RDATA_ACK;
                            end else begin
                                shift_q   <= {shift_q[6:0], 1'b0};
                                sda_oe_q  <= ~shift_q[6];
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise_q) begin
                            if (!sda_h_q) begin
                                ptr_q     <= ptr_q + 2'd1;
                                rd_load_q <= 1'b1;  // next byte loads on the next fall
                                state_q   <= S_RDATA;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= S_WAIT;
                            end
                        end
                    end
                    default: ;  // S_IDLE, S_WAIT: only START/STOP matter
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
//
// Directed I2C controller model driving i2c_target_regs through writes,
// burst wrap, repeated-START reads, address mismatch, an aborted byte and a
// reset in the middle of a read. SDA is modelled as a wired-AND of the
// controller and the target's open-drain output.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;

    localparam int QTR = 8;  // clk cycles per quarter SCL period

    logic        clk;
    logic        rst_n;
    logic        scl;
    logic        m_sda;
    logic        sda_line;
    logic        sda_oe;
    logic [31:0] regs_out;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic        busy;
    logic [3:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] exp_q[$];  // expected wr_index sequence
    int         oe_cnt;    // cycles with sda_oe asserted

    assign sda_line = m_sda & ~sda_oe;

    i2c_target_regs #(.TARGET_ADDR(7'h2A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Strobe scoreboard: each pulse must match the next expected index.
    always @(negedge clk) begin
        if (rst_n && sda_oe) oe_cnt++;
        if (rst_n && wr_strobe) begin
            if (exp_q.size() == 0) check("strb_unexpected", {30'd0, wr_index}, 32'hFFFF_FFFF);
            else check("strb_idx", {30'd0, wr_index}, {30'd0, exp_q.pop_front()});
        end
    end

    // ---------------- bus driver tasks ----------------
    task automatic wait_q();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic i2c_start();   // from idle bus (SCL=1, SDA=1)
        m_sda = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic i2c_rstart();  // from SCL low
        m_sda = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();    // from SCL low
        m_sda = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wait_q();
        scl = 1'b1; wait_q(); wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        b = sda_line; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input string tag, input logic [7:0] d, input logic exp_ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        check(tag, {31'd0, ~b}, {31'd0, exp_ack});
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp_d, input logic m_ack);
        logic       b;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~m_ack);
        check(tag, {24'd0, d}, {24'd0, exp_d});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic b;
        rst_n  = 1'b0;
        scl    = 1'b1;
        m_sda  = 1'b1;
        oe_cnt = 0;
        repeat (4) @(negedge clk);
        check("rst_sda_oe",    {31'd0, sda_oe},    32'd0);
        check("rst_regs",      regs_out,           32'd0);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_index",  {30'd0, wr_index},  32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_state",     {28'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        repeat (4 * QTR) @(negedge clk);

        // Single write: reg1 = 0xA5
        exp_q.push_back(2'd1);
        i2c_start();
        send_byte("t1_ack_addr", 8'h54, 1'b1);
        check("t1_busy_on", {31'd0, busy}, 32'd1);
        send_byte("t1_ack_ptr",  8'h01, 1'b1);
        send_byte("t1_ack_data", 8'hA5, 1'b1);
        i2c_stop();
        wait_q();
        check("t1_regs", regs_out, 32'h0000_A500);
        check("t1_busy_off", {31'd0, busy}, 32'd0);
        check("t1_strb_left", exp_q.size(), 32'd0);

        // Burst write with pointer wrap: reg3 = 0x11, reg0 = 0x22
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        i2c_start();
        send_byte("t2_ack_addr", 8'h54, 1'b1);
        send_byte("t2_ack_ptr",  8'h03, 1'b1);
        send_byte("t2_ack_d0",   8'h11, 1'b1);
        send_byte("t2_ack_d1",   8'h22, 1'b1);
        i2c_stop();
        wait_q();
        check("t2_regs", regs_out, 32'h1100_A522);
        check("t2_strb_left", exp_q.size(), 32'd0);

        // Load 0x11..0x44, then write ptr 2, repeated START, read two bytes
        for (int i = 0; i < 4; i++) exp_q.push_back(i[1:0]);
        i2c_start();
        send_byte("t3_ack_addr", 8'h54, 1'b1);
        send_byte("t3_ack_ptr",  8'h00, 1'b1);
        send_byte("t3_ack_w0",   8'h11, 1'b1);
        send_byte("t3_ack_w1",   8'h22, 1'b1);
        send_byte("t3_ack_w2",   8'h33, 1'b1);
        send_byte("t3_ack_w3",   8'h44, 1'b1);
        i2c_stop();
        wait_q();
        check("t3_regs", regs_out, 32'h4433_2211);
        check("t3_strb_left", exp_q.size(), 32'd0);
        i2c_start();
        send_byte("t3_ack_waddr", 8'h54, 1'b1);
        send_byte("t3_ack_rptr",  8'h02, 1'b1);
        i2c_rstart();
        send_byte("t3_ack_raddr", 8'h55, 1'b1);
        recv_byte("t3_rd0", 8'h33, 1'b1);
        recv_byte("t3_rd1", 8'h44, 1'b0);
        check("t3_oe_after_nack",   {31'd0, sda_oe}, 32'd0);
        check("t3_busy_after_nack", {31'd0, busy},   32'd0);
        i2c_stop();
        wait_q();
        check("t3_busy_after_stop", {31'd0, busy}, 32'd0);

        // Address mismatch: target never drives SDA
        oe_cnt = 0;
        i2c_start();
        send_byte("t4_nack_addr", 8'h56, 1'b0);
        send_byte("t4_nack_ptr",  8'h01, 1'b0);
        send_byte("t4_nack_data", 8'hFF, 1'b0);
        i2c_stop();
        wait_q();
        check("t4_oe_cnt", oe_cnt, 32'd0);
        check("t4_regs", regs_out, 32'h4433_2211);

        // Aborted byte: 5 bits of 0xC3 then STOP, then a good write to reg0
        i2c_start();
        send_byte("t5_ack_addr", 8'h54, 1'b1);
        send_byte("t5_ack_ptr",  8'h00, 1'b1);
        write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
        write_bit(1'b0); write_bit(1'b0);
        i2c_stop();
        wait_q();
        check("t5_regs_abort", regs_out, 32'h4433_2211);
        exp_q.push_back(2'd0);
        i2c_start();
        send_byte("t5_ack_addr2", 8'h54, 1'b1);
        send_byte("t5_ack_ptr2",  8'h00, 1'b1);
        send_byte("t5_ack_data2", 8'h5A, 1'b1);
        i2c_stop();
        wait_q();
        check("t5_regs_good", regs_out, 32'h4433_225A);
        check("t5_strb_left", exp_q.size(), 32'd0);

        // Reset while the target drives bit 7 (=0) of reg2 = 0x33
        i2c_start();
        send_byte("t6_ack_waddr", 8'h54, 1'b1);
        send_byte("t6_ack_ptr",   8'h02, 1'b1);
        i2c_rstart();
        send_byte("t6_ack_raddr", 8'h55, 1'b1);
        check("t6_drive_bit7", {31'd0, sda_oe}, 32'd1);
        check("t6_busy",       {31'd0, busy},   32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_oe",   {31'd0, sda_oe}, 32'd0);
        check("t6_rst_regs", regs_out,        32'd0);
        check("t6_rst_busy", {31'd0, busy},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_sda = 1'b1;
        scl   = 1'b1;
        wait_q(); wait_q();
        exp_q.push_back(2'd3);
        i2c_start();
        send_byte("t6_ack_addr2", 8'h54, 1'b1);
        send_byte("t6_ack_ptr2",  8'h03, 1'b1);
        send_byte("t6_ack_data2", 8'h7E, 1'b1);
        i2c_stop();
        wait_q();
        check("t6_regs_after", regs_out, 32'h7E00_0000);
        check("t6_strb_left", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) with a 4-entry 8-bit register file, for tiles that are configured from an external I2C controller over two bidirectional pins. It decodes START/STOP, matches a 7-bit address, and accepts register writes or returns register reads, with pointer auto-increment. It sits between the top-level `uio_in`/`uio_oe` pins (open-drain SDA, input-only SCL) and the tile's datapath. The datapath consumes `regs_out` and `wr_strobe`.

## Interface
- `TARGET_ADDR`, default 7'h2A: 7-bit I2C address this block answers to.
- `clk` in 1: system clock; must be at least 10x the SCL frequency.
- `rst_n` in 1: synchronous, active-low reset.
- `scl_in` in 1: raw SCL pin, asynchronous.
- `sda_in` in 1: raw SDA pin, asynchronous.
- `sda_oe` out 1: 1 = pull SDA low; 0 = release. The top level drives `uio_out` = 0 on this pin.
- `regs_out` out 32: {reg3, reg2, reg1, reg0}.
- `wr_strobe` out 1: one-cycle pulse when a register is written.
- `wr_index` out 2: index of the register written; valid when `wr_strobe` = 1.
- `busy` out 1: 1 while an addressed transaction is active, from address ACK until STOP, START or NACK.

## Operation
- **Synchronizer and edge detect:**
  - SCL and SDA each pass through a 2-flop synchronizer plus a history flop; all three reset to 1.
  - Edges are detected on the synchronized values.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- **START, from any state** (includes repeated START): go to ADDR, clear the bit counter, release `sda_oe`, set `busy` = 0.
- **STOP, from any state:** go to IDLE, release `sda_oe`, set `busy` = 0.
- **Bit sampling:** on each SCL rise, shift in SDA MSB-first. After 8 bits:
  - ADDR: if the address matches, go to ADDR_ACK, then PTR (R/W = 0) or RDATA (R/W = 1). On mismatch, go to WAIT (SDA never driven).
  - PTR: pointer = byte[1:0]; bits [7:2] are ignored. ACK, then go to WDATA.
  - WDATA: write reg[pointer] = byte, pulse `wr_strobe` with `wr_index` = pointer, pointer += 1 (wrapping 3→0). ACK, then go to WDATA again.
- **ACK drive:** `sda_oe` = 1 from the SCL fall after bit 8 until the SCL fall after the 9th clock.
- **RDATA:**
  - On the SCL fall that ends the address ACK or the previous RDATA_ACK, load the shift register with reg[pointer] and drive bit 7 (`sda_oe` = ~bit).
  - Each following SCL fall presents the next bit.
  - After bit 0, release SDA for the 9th clock (RDATA_ACK) and sample SDA on that SCL rise:
    - ACK (0): pointer += 1 (wrap), go to RDATA.
    - NACK (1): go to WAIT.
- **WAIT:** ignore the bus until START or STOP.
- **Priority:** a STOP/START detected in the same cycle as an SCL edge wins. A write is committed only on the 8th-bit rise, so STOP mid-byte discards partial data.
- A write-then-repeated-START-read uses the pointer as last written or incremented.

## Timing
- **Reset values:** `sda_oe` = 0, `regs_out` = 0, `wr_strobe` = 0, `wr_index` = 0, `busy` = 0, pointer = 0, state IDLE.
- **Pin-to-detect latency:** 3 `clk` cycles (2 sync + 1 edge register).
- **`sda_oe` response:** changes on the `clk` cycle after SCL-fall detection, i.e. 4 `clk` after the pin edge; this is well inside SCL low time at a 10x clock ratio.
- **Register write commit:**
  - `regs_out` and `wr_index` update in the cycle after the 8th-bit SCL-rise detection; `wr_strobe` is high for exactly that cycle.
  - The pointer increments in the same cycle.
- **`busy`:** rises with the address-ACK drive cycle.
- **Reset mid-transaction:** all state returns to reset values on the next `clk` edge. SDA is released immediately; the bus is re-acquired only at the next START.

## Test plan
- **Single write:** START, 0x54 (0x2A+W), 0x01, 0xA5, STOP → ACK on all 3 bytes; `regs_out`[15:8] = 0xA5; exactly one `wr_strobe` with `wr_index` = 1; the other registers stay 0.
- **Burst write with wrap:** ptr 0x03, then data 0x11, 0x22 → reg3 = 0x11, reg0 = 0x22; 2 strobes with indices 3, 0.
- **Read with repeated START:** regs = {0x44, 0x33, 0x22, 0x11}; write ptr 0x02, Sr, 0x55 (R), master ACK then NACK → bytes read 0x33, 0x44; SDA released after NACK; `busy` = 0 after STOP.
- **Address mismatch:** START, 0x56, 0x01, 0xFF → `sda_oe` never asserted; regs unchanged; no strobe.
- **Aborted byte:** STOP after 5 data bits of 0xC3 → no strobe, registers unchanged; the next valid write succeeds.
- **Reset mid-read:** `rst_n` = 0 while driving a 0 bit → `sda_oe` = 0 on the next `clk`; regs cleared; a fresh write transaction then works.
